// File: rtl/dot_acc_pkg.sv
// Shared constants for the multiply-accumulate datapath: accumulator FSM states
// and guard-bit sizing reused by the multiplier and later MAC stages.
package dot_acc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned GUARD_BITS = 8;
    localparam int unsigned CNT_BITS   = 8;

endpackage

// File: rtl/dot_acc.sv
// Streaming dot-product accumulator: sums p_terms consecutive products from the
// shift-add multiplier and presents the result on a valid/ready port.
module dot_acc
    import dot_acc_pkg::*;
#(
    parameter int unsigned p_width = 4,
    parameter int unsigned p_terms = 4
) (
    input  logic                   i_w_clk,
    input  logic                   i_w_rst_n,
    input  logic                   i_w_clear,
    input  logic                   i_w_valid,
    output logic                   o_w_ready,
    input  logic [2*p_width:0]     i_w_prod,
    output logic                   o_w_valid,
    input  logic                   i_w_ready,
    output logic [2*p_width+8:0]   o_w_sum
);

    localparam int unsigned PW = 2*p_width + 1;
    localparam int unsigned SW = PW + GUARD_BITS;
    localparam logic [CNT_BITS:0] TERMS = (CNT_BITS+1)'(p_terms);

    state_t                state, state_nxt;
    logic [SW-1:0]         acc, acc_nxt;
    logic [CNT_BITS-1:0]   cnt, cnt_nxt;
    logic [CNT_BITS:0]     cnt_inc;
    logic                  last_term;

    // One extra bit so the final term of a 256-term sum compares correctly;
    // the wrapped 8-bit count is never used once the FSM reaches DONE.
    assign cnt_inc   = {1'b0, cnt} + {{CNT_BITS{1'b0}}, 1'b1};
    assign last_term = (cnt_inc == TERMS);

    always_ff @(posedge i_w_clk or negedge i_w_rst_n) begin
        if (!i_w_rst_n) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        if (i_w_clear) begin
            state_nxt = IDLE;
            acc_nxt   = '0;
            cnt_nxt   = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (i_w_valid) begin
                        acc_nxt   = SW'(i_w_prod);
                        cnt_nxt   = cnt_inc[CNT_BITS-1:0];
                        state_nxt = last_term ? DONE : ACC;
                    end
                end
                ACC: begin
                    if (i_w_valid) begin
                        acc_nxt   = acc + SW'(i_w_prod);
                        cnt_nxt   = cnt_inc[CNT_BITS-1:0];
                        state_nxt = last_term ? DONE : ACC;
                    end
                end
                DONE: begin
                    if (i_w_ready) begin
                        state_nxt = IDLE;
                        acc_nxt   = '0;
                        cnt_nxt   = '0;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    acc_nxt   = '0;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    assign o_w_ready = (state != DONE);
    assign o_w_valid = (state == DONE);
    assign o_w_sum   = acc;

endmodule
